// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and FSM encoding for the AXI read-channel arbiter.
// The R channel routes responses by these ids, so they must match what AR issues.
package axi_rd_arbiter_pkg;
  localparam logic [3:0] INST_ID        = 4'd0;
  localparam logic [3:0] DATA_ID        = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_AR_WAIT = 1'b1
  } ar_state_e;
endpackage

// File: rtl/axi_rd_arbiter_outstanding.sv
// Per-id outstanding-read counter: saturating up/down with full/empty flags.
module axi_rd_arbiter_outstanding #(
  parameter int MAX = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [2:0] o_cnt,
  output logic       o_full,
  output logic       o_empty
);
  logic [2:0] r_cnt;
  logic       w_up;
  logic       w_dn;

  assign o_full  = (r_cnt >= 3'(MAX));
  assign o_empty = (r_cnt == 3'd0);
  assign o_cnt   = r_cnt;
  assign w_up    = i_inc && !o_full;
  assign w_dn    = i_dec && !o_empty;

  // A simultaneous issue and completion cancel out.
  always_ff @(posedge clk) begin
    if (reset)              r_cnt <= 3'd0;
    else if (w_up && !w_dn) r_cnt <= r_cnt + 3'd1;
    else if (w_dn && !w_up) r_cnt <= r_cnt - 3'd1;
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 AR/R channel between the inst and data SRAM-like read ports.
// Grants one AR per two cycles, tags by arid, and demuxes R beats back by rid.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  input  logic        data_rd_block,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  ar_state_e   r_state;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_rd_err;
  logic [SW-1:0] r_starve;

  logic       w_inst_full, w_inst_empty, w_data_full, w_data_empty;
  logic [2:0] w_inst_cnt, w_data_cnt;
  logic       w_inst_elig, w_data_elig, w_idle, w_starved;
  logic       w_grant_inst, w_grant_data, w_grant;
  logic       w_rhs, w_id_empty, w_bad;

  assign w_idle       = (r_state == ST_IDLE) && !reset;
  assign w_inst_elig  = inst_req && !w_inst_full;
  assign w_data_elig  = data_req && !w_data_full && !data_rd_block;
  assign w_starved    = (r_starve == SW'(STARVE_LIMIT));
  assign w_grant_inst = w_idle && w_inst_elig && (!w_data_elig || w_starved);
  assign w_grant_data = w_idle && w_data_elig && !w_grant_inst;
  assign w_grant      = w_grant_inst || w_grant_data;

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;

  // R is accepted every cycle once out of reset; a beat only completes a
  // read if its id actually has one outstanding.
  assign w_rhs        = rvalid && r_rready && !reset;
  assign inst_data_ok = w_rhs && (rid == INST_ID) && !w_inst_empty;
  assign data_data_ok = w_rhs && (rid == DATA_ID) && !w_data_empty;
  assign inst_rdata   = inst_data_ok ? rdata : 32'd0;
  assign data_rdata   = data_data_ok ? rdata : 32'd0;

  assign w_id_empty = (rid == INST_ID) ? w_inst_empty :
                      (rid == DATA_ID) ? w_data_empty : 1'b1;
  assign w_bad      = w_rhs && (w_id_empty || (rresp != 2'b00));

  axi_rd_arbiter_outstanding #(.MAX(MAX_OUTSTANDING)) u_inst_cnt (
    .clk(clk), .reset(reset),
    .i_inc(w_grant_inst), .i_dec(inst_data_ok && rlast),
    .o_cnt(w_inst_cnt), .o_full(w_inst_full), .o_empty(w_inst_empty)
  );

  axi_rd_arbiter_outstanding #(.MAX(MAX_OUTSTANDING)) u_data_cnt (
    .clk(clk), .reset(reset),
    .i_inc(w_grant_data), .i_dec(data_data_ok && rlast),
    .o_cnt(w_data_cnt), .o_full(w_data_full), .o_empty(w_data_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_arvalid <= 1'b0;
      r_arid    <= 4'd0;
      r_araddr  <= 32'd0;
      r_arsize  <= 3'd0;
      r_rready  <= 1'b0;
    end else begin
      r_rready <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_grant) begin
          r_arid    <= w_grant_inst ? INST_ID : DATA_ID;
          r_araddr  <= w_grant_inst ? inst_addr : data_addr;
          r_arsize  <= {1'b0, (w_grant_inst ? inst_size : data_size)};
          r_arvalid <= 1'b1;
          r_state   <= ST_AR_WAIT;
        end
        ST_AR_WAIT: if (arready) begin
          r_arvalid <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Starvation only accrues while inst could have gone but data won.
  always_ff @(posedge clk) begin
    if (reset || !inst_req || w_grant_inst) r_starve <= '0;
    else if (w_grant_data && w_inst_elig && !w_starved) r_starve <= r_starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)      r_rd_err <= 1'b0;
    else if (w_bad) r_rd_err <= 1'b1;
  end

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arvalid = r_arvalid;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = r_rready;
  assign rd_err  = r_rd_err;

  // Counter values are kept visible on the flags; raw counts are unused here.
  logic w_unused;
  assign w_unused = ^{w_inst_cnt, w_data_cnt};
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed-vector bench for axi_rd_arbiter: one task per scenario, inline checks.
module tb_axi_rd_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_rd_block;
  logic [31:0] inst_addr, data_addr;
  logic [1:0]  inst_size, data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, rd_err;

  int n_cmp = 0;
  int n_err = 0;

  axi_rd_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_rd_block(data_rd_block), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0; inst_size = 0;
    data_req = 0; data_addr = 0; data_size = 0; data_rd_block = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if ({arvalid, arid, araddr, arsize} !== 40'd0) begin n_err++;
      $display("FAIL reset_ar: got %h want 0", {arvalid, arid, araddr, arsize}); end
    n_cmp++; if ({rready, rd_err, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 6'd0) begin n_err++;
      $display("FAIL reset_ctl: got %b want 000000", {rready, rd_err, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    n_cmp++; if ({arlen, arburst, arlock, arcache, arprot} !== {8'd0, 2'b01, 2'd0, 4'd0, 3'd0}) begin n_err++;
      $display("FAIL reset_const: got %h want %h", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'd0, 4'd0, 3'd0}); end
    n_cmp++; if ({inst_rdata, data_rdata} !== 64'd0) begin n_err++;
      $display("FAIL reset_rdata: got %h want 0", {inst_rdata, data_rdata}); end
    tick();
    @(negedge clk);
    n_cmp++; if (rready !== 1'b1) begin n_err++;
      $display("FAIL rready_after_reset: got %b want 1", rready); end
    tick();
  endtask

  task automatic test_single_inst();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2; arready = 1;
    @(negedge clk);
    n_cmp++; if ({inst_addr_ok, data_addr_ok, arvalid} !== 3'b100) begin n_err++;
      $display("FAIL single_grant: got %b want 100", {inst_addr_ok, data_addr_ok, arvalid}); end
    tick();
    inst_req = 0;
    @(negedge clk);
    n_cmp++; if ({arvalid, arid, araddr, arsize, inst_addr_ok} !== {1'b1, 4'd0, 32'hBFC00000, 3'd2, 1'b0}) begin n_err++;
      $display("FAIL single_ar: got %h want %h", {arvalid, arid, araddr, arsize, inst_addr_ok}, {1'b1, 4'd0, 32'hBFC00000, 3'd2, 1'b0}); end
    tick();
    rvalid = 1; rid = 0; rdata = 32'h3C08BFAF;
    @(negedge clk);
    n_cmp++; if ({inst_data_ok, inst_rdata, data_data_ok, arvalid} !== {1'b1, 32'h3C08BFAF, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL single_r: got %h want %h", {inst_data_ok, inst_rdata, data_data_ok, arvalid}, {1'b1, 32'h3C08BFAF, 1'b0, 1'b0}); end
    tick();
    rvalid = 0;
    @(negedge clk);
    n_cmp++; if ({inst_data_ok, inst_rdata, rd_err} !== 34'd0) begin n_err++;
      $display("FAIL single_after: got %h want 0", {inst_data_ok, inst_rdata, rd_err}); end
    tick();
  endtask

  task automatic test_starve();
    logic [3:0] seq [$];
    logic [3:0] exp_seq [10] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
    logic       pend = 0;
    logic [3:0] pend_id = 0;
    int         both = 0;
    do_reset();
    inst_req = 1; data_req = 1; arready = 1; inst_addr = 32'h100; data_addr = 32'h200;
    for (int c = 0; c < 20; c++) begin
      rvalid = pend; rid = pend_id;
      @(negedge clk);
      if (inst_addr_ok && data_addr_ok) both++;
      pend = arvalid; pend_id = arid;
      if (arvalid) seq.push_back(arid);
      tick();
    end
    rvalid = 0; inst_req = 0; data_req = 0;
    n_cmp++; if (seq.size() !== 10) begin n_err++;
      $display("FAIL starve_count: got %0d ARs want 10", seq.size()); end
    for (int i = 0; i < 10 && i < seq.size(); i++) begin
      n_cmp++; if (seq[i] !== exp_seq[i]) begin n_err++;
        $display("FAIL starve_arid[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]); end
    end
    n_cmp++; if (both !== 0) begin n_err++;
      $display("FAIL starve_dual_ok: got %0d cycles want 0", both); end
    tick();
  endtask

  task automatic test_ar_stall();
    int bad = 0;
    do_reset();
    data_req = 1; data_addr = 32'h8000_1234; data_size = 1; arready = 0;
    @(negedge clk);
    n_cmp++; if (data_addr_ok !== 1'b1) begin n_err++;
      $display("FAIL stall_grant: got %b want 1", data_addr_ok); end
    tick();
    data_addr = 32'h8000_9999;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if ({arvalid, arid, araddr, arsize, data_addr_ok, inst_addr_ok} !== {1'b1, 4'd1, 32'h8000_1234, 3'd1, 2'b00}) bad++;
      tick();
    end
    n_cmp++; if (bad !== 0) begin n_err++;
      $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    arready = 1;
    @(negedge clk);
    n_cmp++; if ({arvalid, data_addr_ok} !== 2'b10) begin n_err++;
      $display("FAIL stall_hs: got %b want 10", {arvalid, data_addr_ok}); end
    tick();
    @(negedge clk);
    n_cmp++; if ({data_addr_ok, arvalid} !== 2'b10) begin n_err++;
      $display("FAIL stall_resume: got %b want 10", {data_addr_ok, arvalid}); end
    tick();
    data_req = 0;
    @(negedge clk);
    n_cmp++; if ({arvalid, araddr} !== {1'b1, 32'h8000_9999}) begin n_err++;
      $display("FAIL stall_second_ar: got %h want %h", {arvalid, araddr}, {1'b1, 32'h8000_9999}); end
    tick();
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    inst_req = 1; inst_addr = 32'h40; arready = 1;
    @(negedge clk);
    n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++;
      $display("FAIL lim_first: got %b want 1", inst_addr_ok); end
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++;
      $display("FAIL lim_second: got %b want 1", inst_addr_ok); end
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (inst_addr_ok !== 1'b0) begin n_err++;
      $display("FAIL lim_third_blocked: got %b want 0", inst_addr_ok); end
    tick();
    @(negedge clk);
    n_cmp++; if ({inst_addr_ok, arvalid} !== 2'b00) begin n_err++;
      $display("FAIL lim_still_blocked: got %b want 00", {inst_addr_ok, arvalid}); end
    tick();
    data_req = 1; data_addr = 32'h500;
    @(negedge clk);
    n_cmp++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_err++;
      $display("FAIL lim_data_grant: got %b want 10", {data_addr_ok, inst_addr_ok}); end
    tick();
    data_req = 0;
    tick();
    rvalid = 1; rid = 1; rdata = 32'hDDDD_0001;
    @(negedge clk);
    n_cmp++; if ({data_data_ok, data_rdata, inst_data_ok} !== {1'b1, 32'hDDDD_0001, 1'b0}) begin n_err++;
      $display("FAIL lim_ret_data: got %h want %h", {data_data_ok, data_rdata, inst_data_ok}, {1'b1, 32'hDDDD_0001, 1'b0}); end
    tick();
    rid = 0; rdata = 32'h1111_0000;
    @(negedge clk);
    n_cmp++; if ({inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, 32'h1111_0000, 1'b0}) begin n_err++;
      $display("FAIL lim_ret_inst: got %h want %h", {inst_data_ok, inst_rdata, data_data_ok}, {1'b1, 32'h1111_0000, 1'b0}); end
    tick();
    rvalid = 0;
    @(negedge clk);
    n_cmp++; if ({inst_addr_ok, rd_err} !== 2'b10) begin n_err++;
      $display("FAIL lim_reopen: got %b want 10", {inst_addr_ok, rd_err}); end
    tick();
    inst_req = 0;
    tick();
  endtask

  task automatic test_rd_block();
    do_reset();
    data_req = 1; data_rd_block = 1; data_addr = 32'h600;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({data_addr_ok, arvalid} !== 2'b00) begin n_err++;
        $display("FAIL block_hold[%0d]: got %b want 00", c, {data_addr_ok, arvalid}); end
      tick();
    end
    data_rd_block = 0;
    @(negedge clk);
    n_cmp++; if (data_addr_ok !== 1'b1) begin n_err++;
      $display("FAIL block_release: got %b want 1", data_addr_ok); end
    tick();
    data_req = 0;
    @(negedge clk);
    n_cmp++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h600}) begin n_err++;
      $display("FAIL block_ar: got %h want %h", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h600}); end
    tick();
  endtask

  task automatic test_errors();
    // Unknown rid
    do_reset(); tick();
    rvalid = 1; rid = 2; rdata = 32'hBAD0_0002;
    @(negedge clk);
    n_cmp++; if ({inst_data_ok, data_data_ok, rd_err} !== 3'b000) begin n_err++;
      $display("FAIL err_rid2_beat: got %b want 000", {inst_data_ok, data_data_ok, rd_err}); end
    tick(); rvalid = 0;
    @(negedge clk);
    n_cmp++; if (rd_err !== 1'b1) begin n_err++;
      $display("FAIL err_rid2_flag: got %b want 1", rd_err); end
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (rd_err !== 1'b1) begin n_err++;
      $display("FAIL err_sticky: got %b want 1", rd_err); end
    // rid=0 with nothing outstanding
    do_reset(); tick();
    rvalid = 1; rid = 0;
    @(negedge clk);
    n_cmp++; if ({inst_data_ok, inst_rdata} !== 33'd0) begin n_err++;
      $display("FAIL err_unexp_beat: got %h want 0", {inst_data_ok, inst_rdata}); end
    tick(); rvalid = 0;
    @(negedge clk);
    n_cmp++; if (rd_err !== 1'b1) begin n_err++;
      $display("FAIL err_unexp_flag: got %b want 1", rd_err); end
    // Error response still completes the read
    do_reset();
    inst_req = 1; arready = 1;
    tick(); inst_req = 0; tick();
    rvalid = 1; rid = 0; rresp = 2'b10; rdata = 32'hE0E0;
    @(negedge clk);
    n_cmp++; if ({inst_data_ok, inst_rdata, rd_err} !== {1'b1, 32'hE0E0, 1'b0}) begin n_err++;
      $display("FAIL err_slverr_beat: got %h want %h", {inst_data_ok, inst_rdata, rd_err}, {1'b1, 32'hE0E0, 1'b0}); end
    tick(); rvalid = 0; rresp = 0;
    @(negedge clk);
    n_cmp++; if (rd_err !== 1'b1) begin n_err++;
      $display("FAIL err_slverr_flag: got %b want 1", rd_err); end
    // Reset in the middle of AR_WAIT drops arvalid and forgets the read
    do_reset();
    data_req = 1; data_addr = 32'h700; arready = 0;
    tick(); data_req = 0;
    @(negedge clk);
    n_cmp++; if (arvalid !== 1'b1) begin n_err++;
      $display("FAIL midrst_pre: got %b want 1", arvalid); end
    reset = 1; tick(); reset = 0;
    @(negedge clk);
    n_cmp++; if ({arvalid, arid, araddr, rd_err} !== 38'd0) begin n_err++;
      $display("FAIL midrst_ar: got %h want 0", {arvalid, arid, araddr, rd_err}); end
    tick();
    rvalid = 1; rid = 1;
    @(negedge clk);
    n_cmp++; if (data_data_ok !== 1'b0) begin n_err++;
      $display("FAIL midrst_no_completion: got %b want 0", data_data_ok); end
    tick(); rvalid = 0;
    @(negedge clk);
    n_cmp++; if (rd_err !== 1'b1) begin n_err++;
      $display("FAIL midrst_cnt_cleared: got %b want 1", rd_err); end
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_single_inst();
    test_starve();
    test_ar_stall();
    test_outstanding_limit();
    test_rd_block();
    test_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
